music_playtime_display: RTL and testbench

MUSIC_PLAYTIME_DISPLAY -- requirements
Module: music_playtime_display

---
 rtl/music_playtime_display.sv | 147 ++++++++++++++
 tb/tb_music_playtime_display.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/music_playtime_display.sv
// Music playtime MM:SS counter driving a multiplexed 4-digit seven-segment display.
// Counting runs only while a song is selected, started and not paused.
module music_playtime_display #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int SCAN_DIV = 50_000,
    parameter int WRAP     = 0,
    parameter int BLANK_LZ = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Start,
    input  logic       Pause,
    input  logic [2:0] en,
    output logic [7:0] Digitron_Out,
    output logic [3:0] DigitronCS_Out,
    output logic       Full
);
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
    localparam bit BLANK_EN = (BLANK_LZ != 0);

    logic [PW-1:0] presc;
    logic [SW-1:0] scan_cnt;
    logic [1:0]    digit_idx;
    logic [2:0]    en_q;
    logic [3:0]    sec_units;
    logic [3:0]    sec_tens;
    logic [3:0]    min_units;
    logic [3:0]    min_tens;
    logic [3:0]    cur_digit;
    logic          run;
    logic          tick;
    logic          song_change;
    logic          at_limit;
    logic          blank;

    assign run         = Start & ~Pause & (en != 3'd0);
    assign tick        = run & (presc == PRESC_MAX);
    assign song_change = (en != en_q);
    assign at_limit    = (min_tens == 4'd9) && (min_units == 4'd9) &&
                         (sec_tens == 4'd5) && (sec_units == 4'd9);

    // The prescaler holds while stopped so a resumed second only finishes its remainder.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            en_q  <= en;
            presc <= '0;
        end else begin
            en_q <= en;
            if (song_change) begin
                presc <= '0;
            end else if (run) begin
                presc <= tick ? '0 : presc + 1'b1;
            end
        end
    end

    // A song change beats a coincident tick, so the new song always starts at 00:00.
    always_ff @(posedge CLK) begin
        if (!RST || song_change || (en == 3'd0)) begin
            sec_units <= 4'd0;
            sec_tens  <= 4'd0;
            min_units <= 4'd0;
            min_tens  <= 4'd0;
            Full      <= 1'b0;
        end else if (tick) begin
            if (at_limit) begin
                if (WRAP != 0) begin
                    sec_units <= 4'd0;
                    sec_tens  <= 4'd0;
                    min_units <= 4'd0;
                    min_tens  <= 4'd0;
                    Full      <= 1'b0;
                end else begin
                    Full <= 1'b1;
                end
            end else if (sec_units != 4'd9) begin
                sec_units <= sec_units + 4'd1;
            end else begin
                sec_units <= 4'd0;
                if (sec_tens != 4'd5) begin
                    sec_tens <= sec_tens + 4'd1;
                end else begin
                    sec_tens <= 4'd0;
                    if (min_units != 4'd9) begin
                        min_units <= min_units + 4'd1;
                    end else begin
                        min_units <= 4'd0;
                        min_tens  <= min_tens + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            scan_cnt  <= '0;
            digit_idx <= 2'd0;
        end else if (scan_cnt == SCAN_MAX) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_comb begin
        case (digit_idx)
            2'd0:    cur_digit = sec_units;
            2'd1:    cur_digit = sec_tens;
            2'd2:    cur_digit = min_units;
            default: cur_digit = min_tens;
        endcase
    end

    assign blank = BLANK_EN && (digit_idx == 2'd3) && (min_tens == 4'd0);

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // The dp segment on the minute-units digit doubles as the MM:SS colon.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            Digitron_Out   <= 8'h00;
            DigitronCS_Out <= 4'b0000;
        end else begin
            DigitronCS_Out <= 4'b0001 << digit_idx;
            Digitron_Out   <= blank ? 8'h00 : {(digit_idx == 2'd2), seg7(cur_digit)};
        end
    end
endmodule

// File: tb/tb_music_playtime_display.sv
// Bench for music_playtime_display: a saturating/blanking DUT and a wrapping/unblanked DUT
// share inputs and are compared every cycle against a seconds-based reference model.
module tb_music_playtime_display;
    localparam int CLK_HZ   = 10;
    localparam int SCAN_DIV = 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       Start = 1'b0;
    logic       Pause = 1'b0;
    logic [2:0] en = 3'd1;
    logic [7:0] seg0, seg1;
    logic [3:0] cs0, cs1;
    logic       full0, full1;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    music_playtime_display #(.CLK_HZ(CLK_HZ), .SCAN_DIV(SCAN_DIV), .WRAP(0), .BLANK_LZ(1)) dut0 (
        .CLK(CLK), .RST(RST), .Start(Start), .Pause(Pause), .en(en),
        .Digitron_Out(seg0), .DigitronCS_Out(cs0), .Full(full0)
    );

    music_playtime_display #(.CLK_HZ(CLK_HZ), .SCAN_DIV(SCAN_DIV), .WRAP(1), .BLANK_LZ(0)) dut1 (
        .CLK(CLK), .RST(RST), .Start(Start), .Pause(Pause), .en(en),
        .Digitron_Out(seg1), .DigitronCS_Out(cs1), .Full(full1)
    );

    // Reference model: elapsed playtime as plain seconds, scan position from cycles since reset.
    int         m_secs0, m_secs1, m_presc, m_cyc;
    bit         m_full0;
    logic [2:0] m_enq;
    logic [7:0] e_seg0, e_seg1;
    logic [3:0] e_cs;
    logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic logic [7:0] frame(input int secs, input int idx, input bit blank_lz);
        int d[4];
        d[0] = secs % 10;
        d[1] = (secs % 60) / 10;
        d[2] = (secs / 60) % 10;
        d[3] = secs / 600;
        if (blank_lz && idx == 3 && d[3] == 0) return 8'h00;
        return {(idx == 2) ? 1'b1 : 1'b0, seg_tab[d[idx]]};
    endfunction

    task automatic modelStep();
        bit run;
        int idx;
        if (!RST) begin
            m_secs0 = 0; m_secs1 = 0; m_presc = 0; m_cyc = 0; m_full0 = 0;
            m_enq = en; e_seg0 = 8'h00; e_seg1 = 8'h00; e_cs = 4'b0000;
        end else begin
            idx    = (m_cyc / SCAN_DIV) % 4;
            e_cs   = 4'(1 << idx);
            e_seg0 = frame(m_secs0, idx, 1'b1);
            e_seg1 = frame(m_secs1, idx, 1'b0);
            run    = Start && !Pause && (en != 3'd0);
            if (en != m_enq || en == 3'd0) begin
                m_secs0 = 0; m_secs1 = 0; m_full0 = 0;
                if (en != m_enq) m_presc = 0;
            end else if (run) begin
                if (m_presc == CLK_HZ - 1) begin
                    m_presc = 0;
                    if (m_secs0 == 5999) m_full0 = 1;
                    else m_secs0++;
                    m_secs1 = (m_secs1 + 1) % 6000;
                end else begin
                    m_presc++;
                end
            end
            m_enq = en;
            m_cyc++;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic p, input logic [2:0] e);
        RST = r; Start = s; Pause = p; en = e;
        @(posedge CLK);
        modelStep();
        @(negedge CLK);
        checkOutput("seg0", seg0, e_seg0);
        checkOutput("seg1", seg1, e_seg1);
        checkOutput("cs0", {4'h0, cs0}, {4'h0, e_cs});
        checkOutput("cs1", {4'h0, cs1}, {4'h0, e_cs});
        checkOutput("full0", {7'h0, full0}, {7'h0, m_full0});
        checkOutput("full1", {7'h0, full1}, 8'h00);
    endtask

    task automatic runCycles(input int n, input logic [2:0] e);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 1'b0, e);
    endtask

    // Holds the count with Pause and waits for the requested digit frame.
    task automatic findFrame(input string tag, input logic [3:0] cs, input logic [7:0] exp0,
                             input logic [7:0] exp1);
        bit found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, en);
            if (cs0 == cs) begin
                found = 1;
                checkOutput({tag, "_dut0"}, seg0, exp0);
                checkOutput({tag, "_dut1"}, seg1, exp1);
            end
        end
        if (!found) checkOutput({tag, "_timeout"}, {4'h0, cs0}, {4'h0, cs});
    endtask

    initial begin
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd1);
        checkOutput("reset_seg", seg0, 8'h00);
        checkOutput("reset_cs", {4'h0, cs0}, 8'h00);

        runCycles(650, 3'd1);
        findFrame("t0105_colon", 4'b0100, 8'h86, 8'h86);
        findFrame("t0105_su", 4'b0001, 8'h6D, 8'h6D);

        runCycles(4, 3'd1);
        for (int i = 0; i < 37; i++) applyStimulus(1'b1, 1'b1, 1'b1, 3'd1);
        runCycles(5, 3'd1);
        findFrame("resume_5cyc", 4'b0001, 8'h6D, 8'h6D);
        runCycles(1, 3'd1);
        findFrame("resume_6cyc", 4'b0001, 8'h7D, 8'h7D);

        applyStimulus(1'b0, 1'b1, 1'b0, 3'd1);
        runCycles(79, 3'd1);
        findFrame("t0007", 4'b0001, 8'h07, 8'h07);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd2);
        findFrame("swap_su", 4'b0001, 8'h3F, 8'h3F);
        findFrame("swap_st", 4'b0010, 8'h3F, 8'h3F);
        runCycles(9, 3'd2);
        findFrame("swap_presc9", 4'b0001, 8'h3F, 8'h3F);
        runCycles(1, 3'd2);
        findFrame("swap_presc10", 4'b0001, 8'h06, 8'h06);

        applyStimulus(1'b0, 1'b1, 1'b0, 3'd2);
        runCycles(420, 3'd2);
        findFrame("t0042_su", 4'b0001, 8'h5B, 8'h5B);
        findFrame("t0042_st", 4'b0010, 8'h66, 8'h66);
        findFrame("t0042_mu", 4'b0100, 8'hBF, 8'hBF);
        findFrame("t0042_mt", 4'b1000, 8'h00, 8'h3F);

        runCycles(59560, 3'd2);
        findFrame("t9958_su", 4'b0001, 8'h7F, 8'h7F);
        runCycles(20, 3'd2);
        checkOutput("limit_full0", {7'h0, full0}, 8'h01);
        checkOutput("limit_full1", {7'h0, full1}, 8'h00);
        findFrame("limit_su", 4'b0001, 8'h6F, 8'h3F);
        findFrame("limit_mt", 4'b1000, 8'h6F, 8'h3F);
        runCycles(10, 3'd2);
        findFrame("limit_hold", 4'b0001, 8'h6F, 8'h06);

        applyStimulus(1'b0, 1'b1, 1'b0, 3'd2);
        runCycles(2011, 3'd2);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd2);
        checkOutput("midrst_seg", seg0, 8'h00);
        checkOutput("midrst_cs", {4'h0, cs0}, 8'h00);
        checkOutput("midrst_full", {7'h0, full0}, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd2);
        checkOutput("postrst_seg", seg0, 8'h3F);
        checkOutput("postrst_cs", {4'h0, cs0}, 8'h01);

        for (int k = 0; k < 60; k++) begin
            int         len;
            logic [2:0] e_new;
            logic       s, p;
            len   = $urandom_range(10, 50);
            s     = ($urandom_range(0, 3) != 0);
            p     = ($urandom_range(0, 3) == 0);
            e_new = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : en;
            if ($urandom_range(0, 9) == 0) applyStimulus(1'b0, s, p, e_new);
            for (int c = 0; c < len; c++) applyStimulus(1'b1, s, p, e_new);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
